// File: rtl/ser_8_1_pkg.sv
// Shared phy constants for the serial TX/RX path: the idle/COMMA symbol and
// the serializer's two-state sync FSM encoding.
package ser_8_1_pkg;

  // K28.5; the receive-side aligner searches for this symbol
  localparam logic [7:0] PHY_IDLE_SYM   = 8'hBC;
  localparam int         PHY_SYNC_COUNT = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ser_8_1.sv
// Byte-to-bit serializer: one byte per 8-cycle slot, MSB first, idle symbol
// whenever no valid byte is available and for the first SYNC_COUNT slots.
module ser_8_1
  import ser_8_1_pkg::*;
#(
  parameter logic [7:0] IDLE_SYM   = PHY_IDLE_SYM,
  parameter int         SYNC_COUNT = PHY_SYNC_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic       data_out,
  output logic       byte_start,
  output logic       active
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [3:0] sync_cnt;
  ser_state_e state;
  logic [7:0] sym;

  // Data is only admitted once the sync phase is complete
  always_comb begin
    sym = IDLE_SYM;
    if (state == ACTIVE && valid_in) sym = data_in;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      sync_cnt   <= 4'd0;
      state      <= SYNC;
      data_out   <= 1'b0;
      byte_start <= 1'b0;
      active     <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd0) begin
        data_out   <= sym[7];
        shreg      <= {sym[6:0], 1'b0};
        byte_start <= 1'b1;
        if (state == SYNC) begin
          sync_cnt <= sync_cnt + 4'd1;
          // The slot loaded on this edge is still idle; data starts next slot
          if (sync_cnt == SYNC_LAST) begin
            state  <= ACTIVE;
            active <= 1'b1;
          end
        end
      end else begin
        data_out   <= shreg[7];
        shreg      <= {shreg[6:0], 1'b0};
        byte_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ser_8_1.sv
// Randomized scoreboard bench for ser_8_1: a slot-level model expands each
// sampled byte into eight expected line bits, a monitor compares every cycle.
module tb_ser_8_1;

  localparam logic [7:0] IDLE  = 8'hBC;
  localparam int         NSYNC = 4;

  typedef struct packed {
    logic d;
    logic s;
    logic a;
  } exp_t;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       data_out;
  logic       byte_start;
  logic       active;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t slot_q[$];
  int   slots;

  ser_8_1 #(.IDLE_SYM(8'hBC), .SYNC_COUNT(NSYNC)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .byte_start(byte_start),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference: a slot is 8 line bits; slot k (1-based after reset) carries
  // data only if k > NSYNC, and active is high from slot NSYNC onwards.
  always @(posedge clk_32f) begin
    logic [7:0] symv;
    if (reset) begin
      slot_q.delete();
      slots = 0;
      exp_q.push_back('{d: 1'b0, s: 1'b0, a: 1'b0});
    end else begin
      if (slot_q.size() == 0) begin
        slots++;
        symv = (slots > NSYNC && valid_in) ? data_in : IDLE;
        for (int i = 7; i >= 0; i--)
          slot_q.push_back('{d: symv[i], s: (i == 7), a: (slots >= NSYNC)});
      end
      exp_q.push_back(slot_q.pop_front());
    end
  end

  task automatic chk(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(posedge clk_32f) begin
    exp_t e;
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard at %0t: got empty queue expected entry", $time);
    end else begin
      total--;
      e = exp_q.pop_front();
      chk("data_out", data_out, e.d);
      chk("byte_start", byte_start, e.s);
      chk("active", active, e.a);
    end
  end

  // One 8-cycle slot; optional mid-slot (bit_cnt=3) disturbance of the inputs
  task automatic send_slot(input logic v, input logic [7:0] d, input bit glitch);
    valid_in = v;
    data_in  = d;
    repeat (3) @(negedge clk_32f);
    if (glitch) begin
      valid_in = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom);
    end
    repeat (5) @(negedge clk_32f);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_32f);
    do_reset(2);

    // Idle after reset: five BC symbols, active after the fourth
    repeat (5) send_slot(1'b0, 8'h00, 1'b0);

    // valid during sync is ignored; 3C first appears in slot 5
    do_reset(1);
    repeat (6) send_slot(1'b1, 8'h3C, 1'b0);
    send_slot(1'b1, 8'hA5, 1'b0);
    send_slot(1'b1, 8'hFF, 1'b0);
    send_slot(1'b1, 8'h00, 1'b0);
    send_slot(1'b0, 8'h00, 1'b0);
    send_slot(1'b1, 8'hBC, 1'b0);
    send_slot(1'b1, 8'h5A, 1'b1);

    // Randomized traffic with mid-slot input disturbance
    for (int k = 0; k < 60; k++) begin
      d = ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom);
      send_slot(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)));
    end

    // Reset at bit_cnt=4 of a data byte truncates it
    valid_in = 1'b1;
    data_in  = 8'hE7;
    repeat (4) @(negedge clk_32f);
    do_reset(1);
    repeat (5) send_slot(1'b0, 8'h00, 1'b0);
    send_slot(1'b1, 8'hC3, 1'b0);
    send_slot(1'b1, 8'h81, 1'b1);

    repeat (2) @(negedge clk_32f);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
